// File: rtl/slicel_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : slicel_cfg_loader
// Purpose  : Configuration front-end for the logic slice. It receives one
//            configuration frame as a stream of words over a valid/ready
//            handshake and checks it against a trailing XOR checksum word. A
//            good frame is copied to the slice config outputs, and cen is held
//            high for HOLD_CYCLES cycles. A bad frame never reaches the slice.
// Ports    : cclk                 - config clock, all state on posedge
//            rst                  - synchronous reset, active-high
//            start                - request to begin loading a frame
//            in_data/in_valid     - payload or checksum word, valid flag
//            in_ready             - loader accepts a word this cycle
//            luts_config_out      - to slice luts_config_in
//            inter_lut_mux_config - to slice inter_lut_mux_config
//            config_use_cc        - to slice config_use_cc
//            regs_config_out      - to slice regs_config_in
//            cen                  - slice config enable
//            busy                 - loading, checking or applying
//            done / err           - last frame applied / rejected (levels)
// Revision : 1.0 - initial release
// ============================================================================
module slicel_cfg_loader #(
  parameter int S_XX_BASE   = 4,
  parameter int NUM_LUTS    = 4,
  parameter int CFG_SIZE    = 2*(2**S_XX_BASE)+1,
  parameter int MUX_LVLS    = $clog2(NUM_LUTS),
  parameter int WORD_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int FRAME_BITS  = CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS,
  parameter int NUM_WORDS   = (FRAME_BITS+WORD_W-1)/WORD_W
) (
  input  logic                         cclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_out,
  output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
  output logic                         config_use_cc,
  output logic [2*NUM_LUTS-1:0]        regs_config_out,
  output logic                         cen,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  // Field positions inside the shadow register.
  localparam int LUT_BITS = CFG_SIZE*NUM_LUTS;
  localparam int MUX_LO   = LUT_BITS;
  localparam int CC_BIT   = LUT_BITS + MUX_LVLS;
  localparam int REGS_LO  = CC_BIT + 1;

  localparam int CNT_W  = $clog2(NUM_WORDS+1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_APPLY = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [CNT_W-1:0]        word_cnt;
  logic [WORD_W-1:0]       xor_acc;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [FRAME_BITS-1:0]   shadow;
  logic [FRAME_BITS-1:0]   shadow_d;

  logic xfer;
  logic last_word;
  logic cks_ok;
  logic hold_last;
  logic start_load;
  logic apply_go;

  // in_ready is a pure state decode so the upstream source never sees a
  // combinational path from its own in_valid back to in_ready.
  assign in_ready  = (state == S_LOAD) || (state == S_CHECK);
  assign xfer      = in_valid && in_ready;
  assign last_word = (word_cnt == CNT_W'(NUM_WORDS-1));
  assign cks_ok    = (in_data == xor_acc);
  assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES-1));

  // A new load can only be started from a resting state; start is ignored
  // while a frame is in flight.
  assign start_load = start &&
                      ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign apply_go   = (state == S_CHECK) && xfer && cks_ok;

  // --------------------------------------------------------------------------
  // Shadow slot steering. Word k lands in bits [k*WORD_W +: WORD_W]; the last
  // word is truncated to the frame width, so its upper bits only feed the
  // checksum.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slot
    localparam int LO = k*WORD_W;
    localparam int N  = ((FRAME_BITS - LO) < WORD_W) ? (FRAME_BITS - LO) : WORD_W;
    assign shadow_d[LO +: N] = (word_cnt == CNT_W'(k)) ? in_data[N-1:0]
                                                      : shadow[LO +: N];
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge cclk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    busy    = 1'b0;
    cen     = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (xfer && last_word) state_d = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (xfer) state_d = cks_ok ? S_APPLY : S_ERR;
      end
      S_APPLY: begin
        busy = 1'b1;
        cen  = 1'b1;
        if (hold_last) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_LOAD;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_d = S_LOAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: word counter, running XOR, shadow, apply window, config outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge cclk) begin
    if (rst) begin
      word_cnt             <= '0;
      xor_acc              <= '0;
      hold_cnt             <= '0;
      shadow               <= '0;
      luts_config_out      <= '0;
      inter_lut_mux_config <= '0;
      config_use_cc        <= 1'b0;
      regs_config_out      <= '0;
    end else begin
      if (start_load) begin
        word_cnt <= '0;
        xor_acc  <= '0;
      end else if ((state == S_LOAD) && xfer) begin
        shadow   <= shadow_d;
        xor_acc  <= xor_acc ^ in_data;
        word_cnt <= word_cnt + CNT_W'(1);
      end

      // Config outputs only move on the APPLY entry edge, so they are already
      // stable when cen first rises and stay put afterwards.
      if (apply_go) begin
        luts_config_out      <= shadow[LUT_BITS-1:0];
        inter_lut_mux_config <= shadow[MUX_LO +: MUX_LVLS];
        config_use_cc        <= shadow[CC_BIT];
        regs_config_out      <= shadow[REGS_LO +: 2*NUM_LUTS];
        hold_cnt             <= '0;
      end else if (state == S_APPLY) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/slicel_cfg_loader.md
Name: slicel_cfg_loader

Overview:
- Configuration front-end that sits directly upstream of the standard logic slice on the config clock.
- Accepts the slice's configuration frame as a stream of words over a valid/ready handshake and verifies an XOR checksum.
- On a good frame, drives the slice's config inputs and holds its config-enable (cen) for a fixed number of cycles so the LUTs, mux config, carry-chain select and FF init values are all captured.
- A bad frame never reaches the slice.

Parameters:
- S_XX_BASE, 4, LUT input base (each fracturable LUT has 2*S_XX_BASE inputs).
- NUM_LUTS, 4, LUTs per slice (power of 2).
- CFG_SIZE, 2*(2**S_XX_BASE)+1, config bits per LUT (derived).
- MUX_LVLS, $clog2(NUM_LUTS), inter-LUT mux config width (derived).
- WORD_W, 8, input word width.
- HOLD_CYCLES, 4, cycles cen is held high on apply (>=1).
- FRAME_BITS, CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS, payload bits (derived; 143 at defaults).
- NUM_WORDS, ceil(FRAME_BITS/WORD_W), payload words (derived; 18 at defaults).

Ports:
- cclk  in  1  config clock; all state on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin loading a frame.
- in_data  in  WORD_W  payload or checksum word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- luts_config_out  out  CFG_SIZE*NUM_LUTS  to slice luts_config_in.
- inter_lut_mux_config  out  MUX_LVLS  to slice inter_lut_mux_config.
- config_use_cc  out  1  to slice config_use_cc.
- regs_config_out  out  2*NUM_LUTS  to slice regs_config_in.
- cen  out  1  to slice cen.
- busy  out  1  state is LOAD, CHECK or APPLY.
- done  out  1  last frame applied; level signal.
- err  out  1  last frame failed its checksum; level signal.

Behaviour:
- Reset: state=IDLE. All outputs, the shadow register, the word counter and the running XOR are 0.
- Reset takes priority over every other input. Reset during LOAD, CHECK or APPLY discards the frame, and cen drops the next cycle.
- Frame layout is LSB first: word k fills shadow bits [k*WORD_W +: WORD_W]. Bits at and above FRAME_BITS in the last word are discarded from the shadow but included in the checksum.
- Field map within the shadow:
  - [CFG_SIZE*NUM_LUTS-1:0] = luts_config.
  - Next MUX_LVLS bits = inter_lut_mux_config.
  - Next bit = use_cc.
  - Top 2*NUM_LUTS bits = regs_config.
- Transfer: a word moves on any cclk edge where in_valid && in_ready.
- in_ready is 1 only in LOAD and CHECK, and depends on state only (never on in_valid).
- States:
  - IDLE: start -> LOAD. Clears counter, running XOR, done and err.
  - LOAD: each transfer writes the shadow slot, XORs the word into the running XOR, and increments the counter. The transfer with counter=NUM_WORDS-1 -> CHECK. in_valid gaps stall with no effect.
  - CHECK: one transfer. If word == running XOR -> APPLY: on that same edge copy shadow to all config outputs and set cen=1. Otherwise -> ERR; config outputs keep their previous values and cen stays 0.
  - APPLY: cen=1 for exactly HOLD_CYCLES cycles, counted from the first cycle after the checksum transfer. Then -> DONE with cen=0 and done=1.
  - DONE: done=1. start -> LOAD (clears done).
  - ERR: err=1. start -> LOAD (clears err).
- start is ignored in LOAD, CHECK and APPLY.
- Config outputs change only on the APPLY entry edge, and are stable throughout the cen window and afterwards.
- done and err are never both 1.
- busy = (state in LOAD, CHECK, APPLY).

Test Plan:
- Good frame: reset; start; send 18 words 0x01..0x12 then checksum 0x13 (XOR of 0x01..0x12), in_valid continuous -> in_ready high 19 cycles; cen high exactly 4 cycles starting the cycle after the checksum; luts_config_out[7:0]=0x01; regs_config_out = bits [142:135] of shadow; then done=1, busy=0.
- Bad checksum: same payload, checksum 0x00 -> err=1, cen never asserts, config outputs still equal previous frame's values (all 0 after reset).
- Back-pressure gaps: deassert in_valid for 3 cycles after words 5 and 17 -> same result as the good-frame case, with cen start delayed by 6 cycles.
- Reset mid-load: rst after word 9 -> next cycle in_ready=0, busy=0, all outputs 0; a fresh start plus a full good frame then applies correctly.
- Spurious start: pulse start during LOAD word 4 and during the APPLY window -> no restart, counter unaffected, cen width still 4.
- Reload after done/err: from DONE, start plus a frame with use_cc bit=1 -> done clears on start; config_use_cc=1 from APPLY entry. From ERR, start clears err the next cycle.
